// File: rtl/fht_stage_ctrl.sv
// Stage/sector sequencer for the FHT double-butterfly datapath: walks every stage,
// issues read/write bank addresses and drives the butterfly mode and twiddle inputs.
module fht_stage_ctrl #(
    parameter int A_BIT     = 8,
    parameter int STAGE_NUM = 10,
    parameter int SEC_BIT   = 9,
    parameter int ST_BIT    = 4,
    parameter int RD_LAT    = 1,
    parameter int PIPE_LAT  = 4
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iSTART,
    output logic               oBUSY,
    output logic               oDONE,
    output logic [A_BIT-1:0]   oRD_ADDR,
    output logic               oRD_PAGE,
    output logic [A_BIT-1:0]   oWR_ADDR,
    output logic               oWR_PAGE,
    output logic               oWE,
    output logic [A_BIT-1:0]   oROM_ADDR,
    output logic               oST_ZERO,
    output logic               oST_LAST,
    output logic               o2ND_PART_SUBSEC,
    output logic [SEC_BIT-1:0] oSECTOR,
    output logic [ST_BIT-1:0]  oSTAGE
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam int DR_W   = $clog2(PIPE_LAT + 1);
    localparam int MODE_W = 3 + SEC_BIT + A_BIT;
    localparam int WR_W   = 2 + A_BIT;

    localparam logic [A_BIT-1:0]  RD_MAX     = {A_BIT{1'b1}};
    localparam logic [ST_BIT-1:0] LAST_STAGE = ST_BIT'(STAGE_NUM - 1);
    localparam logic [ST_BIT-1:0] A_BIT_ST   = ST_BIT'(A_BIT);

    logic [1:0]         state_r, state_nx_s;
    logic [ST_BIT-1:0]  stage_r, stage_nx_s;
    logic [A_BIT-1:0]   rd_cnt_r, rd_cnt_nx_s;
    logic [DR_W-1:0]    drain_cnt_r, drain_cnt_nx_s;
    logic               busy_r, done_r;

    logic               in_read_s;
    logic [ST_BIT-1:0]  k_s;
    logic [A_BIT-1:0]   sec_raw_s, second_sh_s, rom_s;
    logic               second_s;
    logic [MODE_W-1:0]  mode_in_s;
    logic [WR_W-1:0]    wr_in_s;

    logic [MODE_W-1:0]  mode_pipe_r [RD_LAT];
    logic [WR_W-1:0]    wr_pipe_r   [PIPE_LAT];

    // Next-state and counter decode for the stage sequencer
    always_comb begin
        state_nx_s     = state_r;
        stage_nx_s     = stage_r;
        rd_cnt_nx_s    = rd_cnt_r;
        drain_cnt_nx_s = drain_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (iSTART) begin
                    state_nx_s  = ST_READ;
                    stage_nx_s  = {ST_BIT{1'b0}};
                    rd_cnt_nx_s = {A_BIT{1'b0}};
                end else begin
                    state_nx_s  = ST_IDLE;
                end
            end
            ST_READ: begin
                if (rd_cnt_r == RD_MAX) begin
                    state_nx_s     = ST_DRAIN;
                    rd_cnt_nx_s    = {A_BIT{1'b0}};
                    drain_cnt_nx_s = DR_W'(PIPE_LAT);
                end else begin
                    rd_cnt_nx_s    = rd_cnt_r + {{(A_BIT-1){1'b0}}, 1'b1};
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == {{(DR_W-1){1'b0}}, 1'b1}) begin
                    drain_cnt_nx_s = {DR_W{1'b0}};
                    if (stage_r == LAST_STAGE) begin
                        state_nx_s = ST_FIN;
                    end else begin
                        state_nx_s  = ST_READ;
                        stage_nx_s  = stage_r + {{(ST_BIT-1){1'b0}}, 1'b1};
                        rd_cnt_nx_s = {A_BIT{1'b0}};
                    end
                end else begin
                    drain_cnt_nx_s = drain_cnt_r - {{(DR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_FIN: begin
                state_nx_s = ST_IDLE;
                stage_nx_s = {ST_BIT{1'b0}};
            end
            default: begin
                state_nx_s     = ST_IDLE;
                stage_nx_s     = {ST_BIT{1'b0}};
                rd_cnt_nx_s    = {A_BIT{1'b0}};
                drain_cnt_nx_s = {DR_W{1'b0}};
            end
        endcase
    end

    // Sequencer state, counters and status flags
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_r     <= ST_IDLE;
            stage_r     <= {ST_BIT{1'b0}};
            rd_cnt_r    <= {A_BIT{1'b0}};
            drain_cnt_r <= {DR_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            stage_r     <= stage_nx_s;
            rd_cnt_r    <= rd_cnt_nx_s;
            drain_cnt_r <= drain_cnt_nx_s;
            busy_r      <= (state_nx_s != ST_IDLE);
            done_r      <= (state_nx_s == ST_FIN);
        end
    end

    assign in_read_s = (state_r == ST_READ);

    // Per-word sector, subsection half and twiddle index; k saturates at A_BIT
    always_comb begin
        if (stage_r > A_BIT_ST) begin
            k_s = A_BIT_ST;
        end else begin
            k_s = stage_r;
        end
        sec_raw_s   = rd_cnt_r >> k_s;
        rom_s       = (rd_cnt_r & ~(RD_MAX << k_s)) << (A_BIT_ST - k_s);
        second_sh_s = rd_cnt_r >> (stage_r - {{(ST_BIT-1){1'b0}}, 1'b1});
        if ((stage_r != {ST_BIT{1'b0}}) && (stage_r <= A_BIT_ST)) begin
            second_s = second_sh_s[0];
        end else begin
            second_s = 1'b0;
        end
        if (in_read_s) begin
            mode_in_s = {(stage_r == {ST_BIT{1'b0}}), (stage_r == LAST_STAGE), second_s,
                         SEC_BIT'(sec_raw_s), rom_s};
            wr_in_s   = {1'b1, rd_cnt_r, ~stage_r[0]};
        end else begin
            mode_in_s = {MODE_W{1'b0}};
            wr_in_s   = {WR_W{1'b0}};
        end
    end

    // Read-latency alignment for mode outputs and datapath-latency write chain
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            for (int i = 0; i < RD_LAT; i++) begin
                mode_pipe_r[i] <= {MODE_W{1'b0}};
            end
            for (int i = 0; i < PIPE_LAT; i++) begin
                wr_pipe_r[i] <= {WR_W{1'b0}};
            end
        end else begin
            mode_pipe_r[0] <= mode_in_s;
            for (int i = 1; i < RD_LAT; i++) begin
                mode_pipe_r[i] <= mode_pipe_r[i-1];
            end
            wr_pipe_r[0] <= wr_in_s;
            for (int i = 1; i < PIPE_LAT; i++) begin
                wr_pipe_r[i] <= wr_pipe_r[i-1];
            end
        end
    end

    assign oBUSY    = busy_r;
    assign oDONE    = done_r;
    assign oRD_ADDR = rd_cnt_r;
    assign oRD_PAGE = stage_r[0];
    assign oSTAGE   = stage_r;

    assign {oST_ZERO, oST_LAST, o2ND_PART_SUBSEC, oSECTOR, oROM_ADDR} = mode_pipe_r[RD_LAT-1];
    assign {oWE, oWR_ADDR, oWR_PAGE} = wr_pipe_r[PIPE_LAT-1];

endmodule

// File: tb/tb_fht_stage_ctrl.sv
// Self-checking bench for fht_stage_ctrl: cycle-position model of the transform
// schedule plus hand-computed spot values.
module tb_fht_stage_ctrl;

    localparam int A_BIT     = 8;
    localparam int STAGE_NUM = 10;
    localparam int SEC_BIT   = 9;
    localparam int ST_BIT    = 4;
    localparam int RD_LAT    = 1;
    localparam int PIPE_LAT  = 4;
    localparam int WORDS     = 1 << A_BIT;
    localparam int PERIOD    = WORDS + PIPE_LAT;
    localparam int DONE_T    = 1 + STAGE_NUM * PERIOD;

    logic               iCLK = 1'b0;
    logic               iRESET;
    logic               iSTART;
    logic               oBUSY, oDONE, oRD_PAGE, oWR_PAGE, oWE;
    logic               oST_ZERO, oST_LAST, o2ND_PART_SUBSEC;
    logic [A_BIT-1:0]   oRD_ADDR, oWR_ADDR, oROM_ADDR;
    logic [SEC_BIT-1:0] oSECTOR;
    logic [ST_BIT-1:0]  oSTAGE;

    fht_stage_ctrl #(
        .A_BIT(A_BIT), .STAGE_NUM(STAGE_NUM), .SEC_BIT(SEC_BIT),
        .ST_BIT(ST_BIT), .RD_LAT(RD_LAT), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
        .oBUSY(oBUSY), .oDONE(oDONE),
        .oRD_ADDR(oRD_ADDR), .oRD_PAGE(oRD_PAGE),
        .oWR_ADDR(oWR_ADDR), .oWR_PAGE(oWR_PAGE), .oWE(oWE),
        .oROM_ADDR(oROM_ADDR), .oST_ZERO(oST_ZERO), .oST_LAST(oST_LAST),
        .o2ND_PART_SUBSEC(o2ND_PART_SUBSEC), .oSECTOR(oSECTOR), .oSTAGE(oSTAGE)
    );

    always #5 iCLK = ~iCLK;

    int checks   = 0;
    int failures = 0;
    bit active   = 1'b0;
    int t        = 0;
    int done_t   = 0;
    int we_count = 0;
    int wr_seen [STAGE_NUM][WORDS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    // Expected outputs derived from the position t within the transform schedule.
    task automatic compare_all();
        int e_busy, e_done, e_rd_addr, e_rd_page, e_stage;
        int e_we, e_wr_addr, e_wr_page;
        int e_zero, e_last, e_2nd, e_sec, e_rom;
        int s, p, k, q;
        e_busy = 0; e_done = 0; e_rd_addr = 0; e_rd_page = 0; e_stage = 0;
        e_we = 0; e_wr_addr = 0; e_wr_page = 0;
        e_zero = 0; e_last = 0; e_2nd = 0; e_sec = 0; e_rom = 0;
        if (active) begin
            e_busy = 1;
            e_done = (t == DONE_T) ? 1 : 0;
            if (t < DONE_T) begin
                s = (t - 1) / PERIOD;
                p = (t - 1) % PERIOD;
                e_stage   = s;
                e_rd_page = s % 2;
                e_rd_addr = (p < WORDS) ? p : 0;
            end else begin
                e_stage   = STAGE_NUM - 1;
                e_rd_page = (STAGE_NUM - 1) % 2;
            end
            q = t - PIPE_LAT;
            if (q >= 1 && q < DONE_T && ((q - 1) % PERIOD) < WORDS) begin
                e_we      = 1;
                e_wr_addr = (q - 1) % PERIOD;
                e_wr_page = 1 - (((q - 1) / PERIOD) % 2);
            end
            q = t - RD_LAT;
            if (q >= 1 && q < DONE_T && ((q - 1) % PERIOD) < WORDS) begin
                s = (q - 1) / PERIOD;
                p = (q - 1) % PERIOD;
                k = (s < A_BIT) ? s : A_BIT;
                e_zero = (s == 0) ? 1 : 0;
                e_last = (s == STAGE_NUM - 1) ? 1 : 0;
                e_sec  = p >> k;
                e_2nd  = (s >= 1 && s <= A_BIT) ? ((p >> (s - 1)) & 1) : 0;
                e_rom  = (p % (1 << k)) << (A_BIT - k);
            end
        end
        chk("busy",    32'(oBUSY),    32'(e_busy));
        chk("done",    32'(oDONE),    32'(e_done));
        chk("rd_addr", 32'(oRD_ADDR), 32'(e_rd_addr));
        chk("rd_page", 32'(oRD_PAGE), 32'(e_rd_page));
        chk("stage",   32'(oSTAGE),   32'(e_stage));
        chk("we",      32'(oWE),      32'(e_we));
        chk("wr_addr", 32'(oWR_ADDR), 32'(e_wr_addr));
        chk("wr_page", 32'(oWR_PAGE), 32'(e_wr_page));
        chk("st_zero", 32'(oST_ZERO), 32'(e_zero));
        chk("st_last", 32'(oST_LAST), 32'(e_last));
        chk("second",  32'(o2ND_PART_SUBSEC), 32'(e_2nd));
        chk("sector",  32'(oSECTOR),  32'(e_sec));
        chk("rom",     32'(oROM_ADDR), 32'(e_rom));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then check.
    task automatic step();
        int s;
        @(posedge iCLK);
        if (iRESET) begin
            active = 1'b0; t = 0;
        end else if (!active) begin
            if (iSTART) begin active = 1'b1; t = 1; end
        end else if (t == DONE_T) begin
            active = 1'b0; t = 0;
        end else begin
            t++;
        end
        #1;
        compare_all();
        if (active && t == 826)  chk("lit_rd_addr_2d", 32'(oRD_ADDR), 32'h2D);
        if (active && t == 827) begin
            chk("lit_s3_sector", 32'(oSECTOR), 32'd5);
            chk("lit_s3_second", 32'(o2ND_PART_SUBSEC), 32'd1);
            chk("lit_s3_rom",    32'(oROM_ADDR), 32'hA0);
        end
        if (active && t == 47) begin
            chk("lit_s0_zero",   32'(oST_ZERO), 32'd1);
            chk("lit_s0_sector", 32'(oSECTOR), 32'h2D);
            chk("lit_s0_rom",    32'(oROM_ADDR), 32'h0);
        end
        if (active && t == 2127) begin
            chk("lit_s8_sector", 32'(oSECTOR), 32'd0);
            chk("lit_s8_rom",    32'(oROM_ADDR), 32'h2D);
            chk("lit_s8_last",   32'(oST_LAST), 32'd0);
        end
        if (active && t == 2387) begin
            chk("lit_s9_sector", 32'(oSECTOR), 32'd0);
            chk("lit_s9_second", 32'(o2ND_PART_SUBSEC), 32'd0);
            chk("lit_s9_last",   32'(oST_LAST), 32'd1);
            chk("lit_s9_zero",   32'(oST_ZERO), 32'd0);
        end
        if (oDONE === 1'b1) done_t = t;
        if (oWE === 1'b1) begin
            we_count++;
            s = (t - PIPE_LAT - 1) / PERIOD;
            if (s >= 0 && s < STAGE_NUM) wr_seen[s][oWR_ADDR]++;
        end
    endtask

    task automatic clear_stats();
        done_t = 0; we_count = 0;
        for (int s = 0; s < STAGE_NUM; s++)
            for (int a = 0; a < WORDS; a++)
                wr_seen[s][a] = 0;
    endtask

    initial begin
        int bad;
        iRESET = 1'b1;
        iSTART = 1'b1;
        clear_stats();

        // Reset held with start asserted: everything stays zero.
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_busy", 32'(oBUSY), 32'd0);
        end
        iRESET = 1'b0;
        step();
        chk("first_read_busy", 32'(oBUSY), 32'd1);
        chk("first_read_addr", 32'(oRD_ADDR), 32'd0);
        iSTART = 1'b0;

        // Full transform with ignored start pulses mid-run and at done.
        for (int i = 0; i < 3000 && active; i++) begin
            iSTART = (t == 500 || t == DONE_T) ? 1'b1 : 1'b0;
            step();
        end
        iSTART = 1'b0;
        chk("run1_finished", 32'(active), 32'd0);
        chk("run1_done_cycle", 32'(done_t), 32'd2601);
        chk("run1_we_total", 32'(we_count), 32'd2560);
        bad = 0;
        for (int s = 0; s < STAGE_NUM; s++)
            for (int a = 0; a < WORDS; a++)
                if (wr_seen[s][a] != 1) bad++;
        chk("run1_wr_cover", 32'(bad), 32'd0);
        for (int i = 0; i < 3; i++) step();
        chk("idle_after_done", 32'(oBUSY), 32'd0);

        // Restart, then reset in the middle of stage 3.
        clear_stats();
        iSTART = 1'b1;
        step();
        iSTART = 1'b0;
        for (int i = 0; i < 1200 && active && t != 1000; i++) step();
        chk("reached_t1000", 32'(t), 32'd1000);
        chk("t1000_stage", 32'(oSTAGE), 32'd3);
        iRESET = 1'b1;
        step();
        chk("midrst_we", 32'(oWE), 32'd0);
        chk("midrst_busy", 32'(oBUSY), 32'd0);
        iRESET = 1'b0;
        step();
        step();

        // Fresh start after the mid-transform reset.
        clear_stats();
        iSTART = 1'b1;
        step();
        iSTART = 1'b0;
        for (int i = 0; i < 3000 && active; i++) step();
        chk("run3_finished", 32'(active), 32'd0);
        chk("run3_done_cycle", 32'(done_t), 32'd2601);
        chk("run3_we_total", 32'(we_count), 32'd2560);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
